// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared types and constants for the CPU phase sequencer.
// Holds the state encoding, which is also visible on the phase output,
// the instruction class codes from IR[15:14] and the HALT opcode.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_PAUSE  = 3'd5,
        ST_HALTED = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    localparam logic [1:0] CLS_MISC = 2'b00;
    localparam logic [1:0] CLS_ALU  = 2'b01;
    localparam logic [1:0] CLS_FILE = 2'b10;
    localparam logic [1:0] CLS_JUMP = 2'b11;

    localparam logic [3:0] OP_HALT = 4'b1111;

    // instr carries IR[15:10]: class in [5:4], misc opcode in [3:0]
    function automatic logic is_halt(input logic [5:0] ins);
        return (ins[5:4] == CLS_MISC) && (ins[3:0] == OP_HALT);
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// seq_wait_timer: wait-state budget for slow data-file accesses.
// Down-counter loaded with WAIT_MAX; tc_o rises once WAIT_MAX waits have
// been counted, i.e. on the last EXEC cycle the sequencer may spend
// waiting before it must give up.
// Ports:
//   clk, rst  clock, asynchronous active-low reset
//   load_i    reload the full wait budget
//   en_i      count one wait cycle
//   tc_o      budget exhausted
module seq_wait_timer #(
    parameter int WAIT_MAX = 15,
    localparam int W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(WAIT_MAX);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: master phase controller for the 8-bit CPU.
// Steps each instruction through FETCH/DECODE/EXEC/WB, stretches EXEC for
// data-file accesses until mem_ready, and supports halt, single-step and a
// wait-state watchdog. All strobes are Moore outputs of the state register.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   start, step          one-cycle pulses (run / release pause)
//   step_mode, halt_req  levels: pause after each instr / request halt
//   instr[5:0]           IR[15:10] from the ROM bus, sampled in DECODE
//   mem_ready            data-file access complete
//   rom_rd, ir_en        FETCH / DECODE strobes
//   pc_inc, pc_load      WB PC update (load for jump class)
//   busy, halted, err    status
//   phase[2:0]           current state encoding
//   instr_count          retired instructions, saturating
//
// state  | meaning
// IDLE   | after reset, waiting for start
// FETCH  | ROM read
// DECODE | IR load, class latched, HALT detected
// EXEC   | execute; file class waits here for mem_ready
// WB     | PC update, instruction retired
// PAUSE  | single-step hold, waiting for step
// HALTED | stopped by HALT op or halt_req
// ERROR  | wait-state watchdog expired, sticky until reset
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic             halt_req,
    input  logic [5:0]       instr,
    input  logic             mem_ready,
    output logic             rom_rd,
    output logic             ir_en,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_q, state_d;
    logic [1:0]       cls_q, cls_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wait_tc;
    logic             wait_en;

    // EXEC is only ever entered from DECODE, so reloading there clears the
    // wait budget on every entry.
    assign wait_en = (state_q == ST_EXEC) && (cls_q == CLS_FILE) && !mem_ready;

    seq_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q == ST_DECODE),
        .en_i   (wait_en),
        .tc_o   (wait_tc)
    );

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                cls_d   = instr[5:4];
                state_d = is_halt(instr) ? ST_HALTED : ST_EXEC;
            end
            ST_EXEC: begin
                if (cls_q != CLS_FILE || mem_ready) state_d = ST_WB;
                else if (wait_tc)                   state_d = ST_ERROR;
            end
            ST_WB: begin
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                if (halt_req)       state_d = ST_HALTED;
                else if (step_mode) state_d = ST_PAUSE;
                else                state_d = ST_FETCH;
            end
            ST_PAUSE: begin
                if (halt_req)  state_d = ST_HALTED;
                else if (step) state_d = ST_FETCH;
            end
            ST_HALTED: if (start && !halt_req) state_d = ST_FETCH;
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cls_q   <= CLS_MISC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rom_rd      = (state_q == ST_FETCH);
    assign ir_en       = (state_q == ST_DECODE);
    assign pc_load     = (state_q == ST_WB) && (cls_q == CLS_JUMP);
    assign pc_inc      = (state_q == ST_WB) && (cls_q != CLS_JUMP);
    assign busy        = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                         (state_q == ST_EXEC)  || (state_q == ST_WB);
    assign halted      = (state_q == ST_HALTED);
    assign err         = (state_q == ST_ERROR);
    assign phase       = state_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
`timescale 1ns/1ps
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, step_mode, step, halt_req, mem_ready;
    logic [5:0]  instr;
    logic        rom_rd, ir_en, pc_inc, pc_load, busy, halted, err;
    logic [2:0]  phase;
    logic [15:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_exec;

    always #5 clk = ~clk;

    cpu_sequencer #(.WAIT_MAX(15), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
        .halt_req(halt_req), .instr(instr), .mem_ready(mem_ready),
        .rom_rd(rom_rd), .ir_en(ir_en), .pc_inc(pc_inc), .pc_load(pc_load),
        .busy(busy), .halted(halted), .err(err), .phase(phase),
        .instr_count(instr_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // strobe vector {rom_rd, ir_en, pc_inc, pc_load, busy, halted, err}
    function automatic logic [6:0] strobes();
        return {rom_rd, ir_en, pc_inc, pc_load, busy, halted, err};
    endfunction

    initial begin
        rst = 1'b0; start = 0; step_mode = 0; step = 0; halt_req = 0;
        mem_ready = 0; instr = 6'b000000;
        #3;
        chk("reset_phase", 32'(phase), 0);
        chk("reset_strobes", 32'(strobes()), 0);
        chk("reset_count", 32'(instr_count), 0);
        tick(); tick();
        rst = 1'b1;

        // ALU op
        instr = 6'b010010; start = 1;
        tick(); start = 0;
        chk("alu_c1_fetch", {29'd0, phase}, 1);
        chk("alu_c1_strobes", 32'(strobes()), 7'b1000100);
        tick();
        chk("alu_c2_ir_en", 32'(strobes()), 7'b0100100);
        tick();
        chk("alu_c3_exec", {29'd0, phase}, 3);
        tick();
        chk("alu_c4_wb", 32'(strobes()), 7'b0010100);
        instr = 6'b110000;
        tick();
        chk("alu_c5_rom_rd", 32'(strobes()), 7'b1000100);
        chk("alu_count", 32'(instr_count), 1);

        // back-to-back jumps
        tick(); tick(); tick();
        chk("jmp1_wb", 32'(strobes()), 7'b0001100);
        tick(); tick(); tick(); tick();
        chk("jmp2_wb_4later", 32'(strobes()), 7'b0001100);
        chk("jmp2_count", 32'(instr_count), 2);

        // file op, mem_ready during 4th EXEC cycle
        instr = 6'b100000; mem_ready = 0;
        tick(); tick();
        n_exec = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (phase == 3'd3) n_exec++;
        end
        chk("file_exec_cycles", 32'(n_exec), 4);
        mem_ready = 1;
        tick(); mem_ready = 0;
        chk("file_wb", 32'(strobes()), 7'b0010100);

        // HALT op
        instr = 6'b001111;
        tick(); tick(); tick();
        chk("halt_phase", {29'd0, phase}, 6);
        chk("halt_strobes", 32'(strobes()), 7'b0000010);
        chk("halt_count", 32'(instr_count), 4);
        halt_req = 1; start = 1;
        tick(); start = 0;
        chk("halt_start_blocked", {29'd0, phase}, 6);
        halt_req = 0; start = 1;
        tick(); start = 0;
        chk("halt_restart", {29'd0, phase}, 1);

        // step mode
        instr = 6'b010010; step_mode = 1;
        tick(); tick(); tick(); tick();
        chk("step_pause", {29'd0, phase}, 5);
        chk("step_count", 32'(instr_count), 5);
        tick();
        chk("step_pause_hold", {29'd0, phase}, 5);
        step = 1;
        tick(); step = 0;
        chk("step_release", {29'd0, phase}, 1);
        tick(); tick(); tick(); tick();
        chk("step_pause2", {29'd0, phase}, 5);
        halt_req = 1; step = 1;
        tick(); halt_req = 0; step = 0;
        chk("pause_halt_wins", {29'd0, phase}, 6);
        chk("count_6", 32'(instr_count), 6);

        // halt_req during WB: PC update completes, then halt
        step_mode = 0; start = 1;
        tick(); start = 0;
        tick(); tick();
        halt_req = 1;
        tick();
        chk("wb_halt_pc_inc", 32'(strobes()), 7'b0010100);
        tick(); halt_req = 0;
        chk("wb_halt_phase", {29'd0, phase}, 6);
        chk("count_7", 32'(instr_count), 7);

        // async reset in EXEC
        start = 1;
        tick(); start = 0;
        tick(); tick();
        chk("pre_rst_exec", {29'd0, phase}, 3);
        #2 rst = 0;
        #1;
        chk("rst_phase", {29'd0, phase}, 0);
        chk("rst_strobes", 32'(strobes()), 0);
        chk("rst_count", 32'(instr_count), 0);
        @(negedge clk); rst = 1;

        // mem_ready on final allowed EXEC cycle -> WB
        instr = 6'b100000; start = 1;
        tick(); start = 0;
        tick();
        n_exec = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (phase == 3'd3) n_exec++;
        end
        chk("edge_exec_cycles", 32'(n_exec), 16);
        mem_ready = 1;
        tick(); mem_ready = 0;
        chk("edge_wb", {29'd0, phase}, 4);

        // watchdog timeout
        tick(); tick();
        n_exec = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (phase == 3'd3) n_exec++;
        end
        chk("to_exec_cycles", 32'(n_exec), 16);
        tick();
        chk("to_error", 32'(strobes()), 7'b0000001);
        chk("to_phase", {29'd0, phase}, 7);
        start = 1;
        tick(); start = 0;
        tick();
        chk("err_sticky", {29'd0, phase}, 7);
        @(negedge clk); rst = 0;
        #1;
        chk("err_cleared", {29'd0, phase}, 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Master timing controller for the 8-bit CPU.
- Steps each instruction through four phases: S1 fetch, S2 decode (pulses ir_en into the instruction register), S3 execute, S4 writeback/PC update.
- Inserts wait states for slow data-file accesses. Supports halt, single-step and a watchdog error.
- Sits between the program counter / instruction ROM and the instruction register. ALU and file units are driven by the IR's own S3/S4 strobes; this block only gates the phase timing.

Parameters:
- WAIT_MAX, 15: maximum S3 wait cycles for mem_ready before the error state.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins execution from IDLE or HALTED.
- step_mode  input  1  1 = pause after every instruction.
- step  input  1  one-cycle pulse; releases PAUSE.
- halt_req  input  1  external halt request, level.
- instr  input  6  instruction bits [15:10] from the ROM data bus; sampled in S2.
- mem_ready  input  1  data-file access complete.
- rom_rd  output  1  ROM read strobe (S1).
- ir_en  output  1  instruction-register load strobe (S2).
- pc_inc  output  1  PC increment (S4, non-jump).
- pc_load  output  1  PC load from IR address (S4, jump class).
- busy  output  1  high in FETCH, DECODE, EXEC, WB.
- halted  output  1  high in HALTED.
- err  output  1  high in ERROR.
- phase  output  3  current state encoding.
- instr_count  output  CNT_W  retired instructions, saturating.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0.
- Moore machine. Every strobe is decoded from the registered state only, so each strobe is high for exactly the cycles spent in its state.
- Instruction class is instr[5:4], which maps to IR bits [15:14]:
  - 00 misc
  - 01 ALU
  - 10 file
  - 11 jump
- Misc op 1111 (instr = 6'b001111) is HALT. Other misc ops are NOP.
- Class and op are latched into cls_q/op_q on the DECODE cycle.
- States and transitions:
  - IDLE: start -> FETCH. Otherwise stay.
  - FETCH: rom_rd=1 -> DECODE unconditionally.
  - DECODE: ir_en=1. Latch instr. HALT op -> HALTED (no PC update, no count). Otherwise -> EXEC.
  - EXEC:
    - Class 10: stay while mem_ready=0, incrementing wait_cnt. mem_ready=1 -> WB. If mem_ready is still 0 when wait_cnt reaches WAIT_MAX -> ERROR, giving WAIT_MAX+1 EXEC cycles in total.
    - Other classes: exactly one cycle -> WB. mem_ready is ignored.
  - WB:
    - Class 11: pc_load=1, pc_inc=0. Otherwise pc_inc=1, pc_load=0.
    - instr_count increments, saturating at all-ones.
    - Next state, in priority order: halt_req=1 -> HALTED; else step_mode=1 -> PAUSE; else FETCH.
  - PAUSE: step -> FETCH. A halt_req seen in PAUSE takes priority -> HALTED.
  - HALTED: halted=1. start -> FETCH, but only when halt_req=0; while halt_req=1, start is ignored.
  - ERROR: err=1. Sticky until rst.
- Nominal latency is 4 cycles per instruction (FETCH, DECODE, EXEC, WB). File ops take 4 + number of wait cycles.
- wait_cnt clears on every entry to EXEC.
- start is ignored outside IDLE/HALTED. step is ignored outside PAUSE.
- halt_req is sampled only in WB and PAUSE. An in-flight instruction always completes its PC update before halting.
- Asynchronous reset mid-instruction: strobes drop immediately, the machine goes to IDLE and the count clears. No partial PC update is issued after reset.
- Simultaneous halt_req and step in PAUSE -> HALTED.
- Simultaneous mem_ready=1 on the WAIT_MAX-th EXEC cycle -> WB, not ERROR.

Decomposition:
- Package cpu_seq_pkg holds:
  - state encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, PAUSE=5, HALTED=6, ERROR=7.
  - class constants: CLS_MISC, CLS_ALU, CLS_FILE, CLS_JUMP.
  - OP_HALT=4'b1111.
- One sub-module, seq_wait_timer: loadable wait counter with a terminal-count flag (clear, enable, tc at WAIT_MAX). The FSM, output decode and instruction counter stay in the top module.

Test Plan:
- ALU op: reset, start with instr=6'b010010 -> rom_rd at cycle 1, ir_en at 2, EXEC at 3, pc_inc at 4, rom_rd again at 5; instr_count=1.
- Jump: instr=6'b110000 -> pc_load=1 and pc_inc=0 in WB; back-to-back jumps give pc_load every 4th cycle.
- File op: instr=6'b100000, mem_ready asserted after 3 EXEC cycles -> 4 EXEC cycles then WB with pc_inc.
- Timeout: file op with mem_ready=0 and WAIT_MAX=15 -> ERROR after 16 EXEC cycles, err=1; stays in ERROR despite start until rst.
- HALT op: instr=6'b001111 -> HALTED right after DECODE, halted=1, no pc_inc, count unchanged; start with halt_req=0 -> FETCH.
- Step mode: step_mode=1 -> PAUSE after each WB; step pulse -> FETCH next cycle. In PAUSE, halt_req and step together -> HALTED. Reset asserted in EXEC -> IDLE, all outputs 0.
